// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: two-port shared 32-bit less-than compare unit (IDLE->CMP->RESP).
// Define CMP_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module cmp_share_arbiter #(
  parameter logic [1:0]  SIGNED                = 2'b00,
  parameter logic [1:0]  UNSIGNED              = 2'b01,
  parameter logic [31:0] LT_RESULT             = 32'h1,
  parameter logic [31:0] OTHERS                = 32'h0,
  parameter logic [31:0] UNKNOWN_OPCODE_RESULT = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_op_a_i,
  input  logic [31:0] req0_op_b_i,
  input  logic [1:0]  req0_opcode_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_op_a_i,
  input  logic [31:0] req1_op_b_i,
  input  logic [1:0]  req1_opcode_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_op_a, r_op_b, r_result;
  logic [1:0]  r_opcode;
  logic        r_id;
  logic        w_pick1, w_accept, w_rsp_take, w_slt;
  logic [31:0] w_diff, w_cmp;
`ifdef CMP_ARB_RR_EN
  logic        r_last;
  assign w_pick1 = req1_valid_i && (!req0_valid_i || !r_last);
  always_ff @(posedge clk_i)
    if (!rst_n_i) r_last <= 1'b1;
    else if (r_state == RESP && w_rsp_take) r_last <= r_id;
`else
  assign w_pick1 = req1_valid_i && !req0_valid_i;
`endif
  // Ready is masked during reset so nothing is granted while the FSM is held.
  assign req0_ready_o = rst_n_i && r_state == IDLE && req0_valid_i && !w_pick1;
  assign req1_ready_o = rst_n_i && r_state == IDLE && w_pick1;
  assign w_accept     = req0_ready_o || req1_ready_o;
  assign w_rsp_take   = r_id ? rsp1_ready_i : rsp0_ready_i;
  assign w_diff       = r_op_a - r_op_b;
  assign w_slt        = (r_op_a[31] != r_op_b[31]) ? r_op_a[31] : w_diff[31];
  always_comb begin
    w_cmp  = r_opcode == SIGNED   ? (w_slt ? LT_RESULT : OTHERS) :
             r_opcode == UNSIGNED ? ((r_op_a < r_op_b) ? LT_RESULT : OTHERS) :
             UNKNOWN_OPCODE_RESULT;
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = CMP;
    else if (r_state == CMP) w_next = RESP;
    else if (r_state == RESP && w_rsp_take) w_next = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
      r_id     <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a   <= req1_ready_o ? req1_op_a_i : req0_op_a_i;
        r_op_b   <= req1_ready_o ? req1_op_b_i : req0_op_b_i;
        r_opcode <= req1_ready_o ? req1_opcode_i : req0_opcode_i;
        r_id     <= req1_ready_o;
      end
      if (r_state == CMP) r_result <= w_cmp;
    end
  end
  assign rsp0_valid_o  = r_state == RESP && !r_id;
  assign rsp1_valid_o  = r_state == RESP && r_id;
  assign rsp0_result_o = rsp0_valid_o ? r_result : '0;
  assign rsp1_result_o = rsp1_valid_o ? r_result : '0;
  assign busy_o        = r_state != IDLE;
endmodule
